// File: rtl/restoring_div16x8_if.sv
// Operand/result bundle for the 16/8 restoring divider: operands and start
// request toward the divider, registered results and status back.
interface restoring_div16x8_if;
    logic [15:0] dividend_i;
    logic [7:0]  divisor_i;
    logic        do_i;
    logic [15:0] quotient_o;
    logic [7:0]  remainder_o;
    logic        div_by_zero_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        output dividend_i, divisor_i, do_i,
        input  quotient_o, remainder_o, div_by_zero_o, busy_o, done_o
    );

    modport slave (
        input  dividend_i, divisor_i, do_i,
        output quotient_o, remainder_o, div_by_zero_o, busy_o, done_o
    );
endinterface

// File: rtl/restoring_div16x8.sv
// Sequential unsigned 16/8 restoring divider: one quotient bit per clock, MSB
// first, fixed 17-clock latency from accept to a one-cycle done pulse.
module restoring_div16x8 (
    input logic                   clk,
    input logic                   reset,
    restoring_div16x8_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_q;
    logic [15:0] q_q;
    logic [7:0]  d_q;
    logic [8:0]  r_q;
    logic [3:0]  cnt_q;
    logic [7:0]  lo_q;
    logic [15:0] quotient_q;
    logic [7:0]  remainder_q;
    logic        dbz_q;
    logic        busy_q;
    logic        done_q;

    logic [8:0]  r_shift_d;
    logic [9:0]  trial_d;
    logic        borrow_d;
    logic [8:0]  r_d;
    logic [15:0] q_d;

    // A set R[8] means the shifted value is at least 512, which always exceeds
    // D, so the subtraction must succeed regardless of the 10-bit borrow.
    always_comb begin
        r_shift_d = {r_q[7:0], q_q[15]};
        trial_d   = {1'b0, r_shift_d} - {2'b00, d_q};
        borrow_d  = trial_d[9] & ~r_q[8];
        if (borrow_d) begin
            r_d = r_shift_d;
            q_d = {q_q[14:0], 1'b0};
        end else begin
            r_d = trial_d[8:0];
            q_d = {q_q[14:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.do_i) begin
                        q_q     <= bus.dividend_i;
                        d_q     <= bus.divisor_i;
                        lo_q    <= bus.dividend_i[7:0];
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    // Divide by zero still costs the full run so latency never varies.
                    if (d_q == 8'd0) begin
                        quotient_q  <= 16'hFFFF;
                        remainder_q <= lo_q;
                        dbz_q       <= 1'b1;
                    end else begin
                        quotient_q  <= q_q;
                        remainder_q <= r_q[7:0];
                        dbz_q       <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.quotient_o    = quotient_q;
    assign bus.remainder_o   = remainder_q;
    assign bus.div_by_zero_o = dbz_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
endmodule
